// File: rtl/img_seq_pkg.sv
// Shared encodings and defaults for the image pixel sequencer.
package img_seq_pkg;

  localparam int PIX_W_DEF = 24;
  localparam int STATE_W   = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] ST_REQ   = 4'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 4'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 4'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 4'd4;
  localparam logic [STATE_W-1:0] ST_ERR   = 4'd5;

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry one cycle after its push.
// Push while full and pop while empty are dropped; flush empties it in one cycle.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: empty/count gate every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/img_pix_sequencer.sv
// Requests pixels one at a time from the source, buffers them and hands them to the CPU
// over valid/ready; src_pix_rdy in cycle N shows on cpu_pix_valid in N+1, requests stall while full.
module img_pix_sequencer
  import img_seq_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               src_get_next,
  input  logic               src_pix_rdy,
  input  logic [PIX_W-1:0]   src_pixel_data,
  input  logic               src_img_done,
  input  logic               cpu_rdy,
  output logic               cpu_pix_valid,
  output logic [PIX_W-1:0]   cpu_pix_rgb,
  output logic [CNT_W-1:0]   pix_count,
  output logic [STATE_W-1:0] out_state,
  output logic               frame_done,
  output logic               timeout_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             get_q, get_d;

  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [PIX_W-1:0] fifo_dout;
  logic             start_ok, push, pop, flush;

  assign start_ok = start && !abort &&
                    (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign pop      = !fifo_empty && cpu_rdy;
  assign push     = (state_q == ST_WAIT) && src_pix_rdy && !abort;
  assign flush    = abort || start_ok;

  pix_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (src_pixel_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    get_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start_ok) begin
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          // At most one request is outstanding, so "not full" guarantees room for its pixel.
          if (src_img_done) begin
            state_d = ST_DRAIN;
          end else if (!fifo_full) begin
            get_d   = 1'b1;
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_d = timer_q + 1'b1;
          if (src_pix_rdy)                         state_d = ST_REQ;
          else if (src_img_done)                   state_d = ST_DRAIN;
          else if (timer_q == TW'(TIMEOUT - 1))    state_d = ST_ERR;
        end
        ST_DRAIN: begin
          if (fifo_count == '0 || (fifo_count == CW'(1) && pop)) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)                               cnt_d = '0;
    else if (pop && (cnt_q != {CNT_W{1'b1}}))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      get_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      get_q   <= get_d;
    end
  end

  // Request pulse is registered, so it coincides with the first WAIT cycle.
  assign src_get_next  = get_q;
  assign cpu_pix_valid = !fifo_empty;
  assign cpu_pix_rgb   = fifo_empty ? '0 : fifo_dout;
  assign pix_count     = cnt_q;
  assign out_state     = state_q;
  assign frame_done    = (state_q == ST_DONE);
  assign timeout_err   = (state_q == ST_ERR);

endmodule

// File: doc/img_pix_sequencer.md
Name: img_pix_sequencer

Overview:
Sequences pixel transfer from the image pixel source into the CPU-side image reader path. Issues one-pixel requests to the source and buffers returned pixels in a small FWFT FIFO. Presents pixels to the CPU consumer over a valid/ready handshake, and tracks frame completion, pixel count and source timeout. Sits between the pixel source (pix_rdy / pixel_data / img_done) and the HPS-facing image reader conduit.

Parameters:
PIX_W, 24, pixel width (RGB888)
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
TIMEOUT, 1023, max cycles in WAIT before error; >= 1
CNT_W, 32, pix_count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin frame
abort  in  1  one-cycle pulse: cancel frame, flush
src_get_next  out  1  one-cycle request pulse for next pixel
src_pix_rdy  in  1  one-cycle pulse: src_pixel_data valid
src_pixel_data  in  PIX_W  pixel from source
src_img_done  in  1  level: source has no further pixels
cpu_rdy  in  1  consumer ready
cpu_pix_valid  out  1  cpu_pix_rgb valid
cpu_pix_rgb  out  PIX_W  head-of-FIFO pixel
pix_count  out  CNT_W  pixels delivered to CPU this frame
out_state  out  4  current FSM state encoding
frame_done  out  1  level, set in DONE until next start/abort
timeout_err  out  1  sticky, set on timeout until next start/abort

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO empty; all outputs 0.
- State encoding: IDLE=0, REQ=1, WAIT=2, DRAIN=3, DONE=4, ERR=5. out_state is driven from the state register.
- IDLE / DONE / ERR + start: clear pix_count, frame_done, timeout_err; flush FIFO; go to REQ.
- start while in REQ / WAIT / DRAIN: ignored.
- REQ:
  - src_img_done=1: go to DRAIN.
  - Else if FIFO count < FIFO_DEPTH: pulse src_get_next for exactly 1 cycle, clear timer, go to WAIT.
  - Else: stay in REQ, no pulse.
- WAIT:
  - Timer increments each cycle.
  - src_pix_rdy=1: push src_pixel_data, go to REQ (pix_rdy takes priority over img_done and timeout in the same cycle).
  - Else if src_img_done=1: go to DRAIN.
  - Else if timer == TIMEOUT-1: go to ERR and set timeout_err.
- DRAIN: go to DONE on the first cycle the FIFO is empty (count==0 after that cycle's pop).
- DONE: frame_done=1.
- ERR: FIFO is not flushed; the CPU may still drain buffered pixels. No further src_get_next.
- abort in any state: go to IDLE; flush FIFO; clear frame_done and timeout_err. pix_count holds.
- abort and start in the same cycle: abort wins.
- src_pix_rdy outside WAIT: ignored, no push.
- CPU side:
  - cpu_pix_valid = FIFO not empty; cpu_pix_rgb = FIFO head.
  - Transfer occurs when cpu_pix_valid & cpu_rdy: pop the FIFO and increment pix_count, saturating at all-ones.
- Latency:
  - src_pix_rdy in cycle N gives cpu_pix_valid in N+1.
  - With cpu_rdy held 1 and the source answering in 1 cycle, throughput is 1 pixel per 3 cycles (REQ→WAIT→REQ).
- Simultaneous push and pop in the same cycle: both occur, count unchanged.
- Push never occurs when full, because requests are gated on count < FIFO_DEPTH.
- Request pulse width is always 1 cycle; back-to-back pulses are never issued.

Decomposition:
- Package img_seq_pkg: state enum and encodings, PIX_W default, out_state width.
- Sub-module pix_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, reset, flush, push, din, pop, dout, empty, full, count.
  - Instantiated once.
- The FSM, timer and pix_count live in the top module.

Test Plan:
- Normal frame: start; source returns 0x112233, 0x445566, 0x778899 one cycle after each src_get_next; src_img_done rises after the third; cpu_rdy=1 -> CPU receives the three pixels in order, pix_count=3, out_state=4, frame_done=1.
- Backpressure: cpu_rdy=0, FIFO_DEPTH=4 -> exactly 4 src_get_next pulses, then out_state holds 1 with no pulse. Raise cpu_rdy -> one pop, then exactly one new src_get_next within 2 cycles.
- Timeout: TIMEOUT=16, source never answers -> ERR 16 cycles after entering WAIT; timeout_err=1, out_state=5, no further src_get_next. Next start clears timeout_err.
- Spurious/late data: src_pix_rdy pulsed in IDLE, and after abort during WAIT -> no push, cpu_pix_valid stays 0, out_state=0.
- Reset mid-frame with 2 pixels buffered: assert reset asynchronously -> all outputs 0 in the same cycle; after release FIFO empty, out_state=0.
- Same-cycle events in WAIT: src_pix_rdy and src_img_done both high -> pixel pushed, then REQ→DRAIN→DONE once the CPU drains it; pix_count increments by 1.
